// File: rtl/add_arbiter.sv
// add_arbiter: round-robin sharing of one 32-bit ripple-carry adder among N
// requesters, sequenced by an IDLE -> ADD -> RESP state machine.
// Optional build macro ADD_ARB_SETTLE_EN stretches ADD to SETTLE cycles with a
// 4-bit down-counter so the full carry ripple has extra time to settle.
module add_arbiter #(
   parameter int N      = 4,
   parameter int IDW    = 2,
   parameter int SETTLE = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req_valid,
   output logic [N-1:0]    req_ready,
   input  logic [N*32-1:0] req_a,
   input  logic [N*32-1:0] req_b,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [IDW-1:0]  rsp_id,
   output logic [31:0]     rsp_sum,
   output logic            rsp_cout,
   output logic            busy
);

   // Reject parameter sets the pointer arithmetic and counter cannot represent.
   if (N < 2 || N > 8 || IDW != $clog2(N) || SETTLE < 1 || SETTLE > 15) begin : g_bad_param
      $error("add_arbiter: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      st_idle = 2'd0,
      st_add  = 2'd1,
      st_resp = 2'd2
   } state_t;

   state_t          state_reg, state_next;
   logic [IDW-1:0]  ptr_reg, ptr_next;
   logic [IDW-1:0]  id_reg, id_next;
   logic [31:0]     op_a_reg, op_a_next;
   logic [31:0]     op_b_reg, op_b_next;
   logic [31:0]     sum_reg, sum_next;
   logic            cout_reg, cout_next;
`ifdef ADD_ARB_SETTLE_EN
   logic [3:0]      cnt_reg, cnt_next;
`endif

   logic [31:0]     a_arr [N];
   logic [31:0]     b_arr [N];
   logic            grant_valid;
   logic [IDW-1:0]  grant_idx;
   logic [IDW:0]    cand;
   logic [N-1:0]    ready_c;
   logic [IDW:0]    id_plus;
   logic [IDW-1:0]  ptr_inc;
   logic [31:0]     add_sum;
   logic            add_cout;

   // Split the packed operand buses into per-requester words.
   genvar gi;
   for (gi = 0; gi < N; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[32*gi +: 32];
      assign b_arr[gi] = req_b[32*gi +: 32];
   end

   // Shared adder: explicit ripple chain of full adders, carry-in fixed at 0.
   // Each stage keeps its own carry net so the chain is not one self-feeding vector.
   for (gi = 0; gi < 32; gi++) begin : g_fa
      logic cin;
      logic co;
      if (gi == 0) begin : g_c0
         assign cin = 1'b0;
      end else begin : g_cn
         assign cin = g_fa[gi-1].co;
      end
      assign add_sum[gi] = op_a_reg[gi] ^ op_b_reg[gi] ^ cin;
      assign co          = (op_a_reg[gi] & op_b_reg[gi]) | (cin & (op_a_reg[gi] ^ op_b_reg[gi]));
   end
   assign add_cout = g_fa[31].co;

   // Round-robin search starting at ptr; scanning backwards lets the smallest offset win.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = {1'b0, ptr_reg} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(N)) begin
            cand = cand - (IDW+1)'(N);
         end
         if (req_valid[cand[IDW-1:0]]) begin
            grant_valid = 1'b1;
            grant_idx   = cand[IDW-1:0];
         end
      end
   end

   // Pointer advances to the requester after the one just served.
   assign id_plus = {1'b0, id_reg} + {{IDW{1'b0}}, 1'b1};
   assign ptr_inc = (id_plus == (IDW+1)'(N)) ? '0 : id_plus[IDW-1:0];

   // Next-state and datapath-load decisions for the IDLE/ADD/RESP sequence.
   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      id_next    = id_reg;
      op_a_next  = op_a_reg;
      op_b_next  = op_b_reg;
      sum_next   = sum_reg;
      cout_next  = cout_reg;
      ready_c    = '0;
`ifdef ADD_ARB_SETTLE_EN
      cnt_next   = cnt_reg;
`endif
      case (state_reg)
         st_idle: begin
            if (grant_valid) begin
               ready_c[grant_idx] = 1'b1;
               op_a_next          = a_arr[grant_idx];
               op_b_next          = b_arr[grant_idx];
               id_next            = grant_idx;
               state_next         = st_add;
`ifdef ADD_ARB_SETTLE_EN
               cnt_next           = 4'(SETTLE - 1);
`endif
            end
         end
         st_add: begin
`ifdef ADD_ARB_SETTLE_EN
            if (cnt_reg == 4'd0) begin
               sum_next   = add_sum;
               cout_next  = add_cout;
               state_next = st_resp;
            end else begin
               cnt_next   = cnt_reg - 4'd1;
            end
`else
            sum_next   = add_sum;
            cout_next  = add_cout;
            state_next = st_resp;
`endif
         end
         st_resp: begin
            if (rsp_ready) begin
               ptr_next   = ptr_inc;
               state_next = st_idle;
            end
         end
         default: begin
            state_next = st_idle;
         end
      endcase
   end

   // State and datapath registers; reset drops any in-flight operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= st_idle;
         ptr_reg   <= '0;
         id_reg    <= '0;
         op_a_reg  <= '0;
         op_b_reg  <= '0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
`ifdef ADD_ARB_SETTLE_EN
         cnt_reg   <= '0;
`endif
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         id_reg    <= id_next;
         op_a_reg  <= op_a_next;
         op_b_reg  <= op_b_next;
         sum_reg   <= sum_next;
         cout_reg  <= cout_next;
`ifdef ADD_ARB_SETTLE_EN
         cnt_reg   <= cnt_next;
`endif
      end
   end

   // No grant is offered while reset is held, even though the state reads IDLE.
   assign req_ready = rst ? '0 : ready_c;
   assign rsp_valid = (state_reg == st_resp);
   assign busy      = (state_reg != st_idle);
   assign rsp_id    = id_reg;
   assign rsp_sum   = sum_reg;
   assign rsp_cout  = cout_reg;

endmodule

// File: tb/tb_add_arbiter.sv
// tb_add_arbiter: directed checks of add_arbiter (reset, latency, arithmetic,
// round-robin order, back-pressure, reset during an operation).
module tb_add_arbiter;

   localparam int N      = 4;
   localparam int IDW    = 2;
   localparam int SETTLE = 4;
`ifdef ADD_ARB_SETTLE_EN
   localparam int LAT = 1 + SETTLE;
`else
   localparam int LAT = 2;
`endif

   logic            clk;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*32-1:0] req_a;
   logic [N*32-1:0] req_b;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [IDW-1:0]  rsp_id;
   logic [31:0]     rsp_sum;
   logic            rsp_cout;
   logic            busy;

   int checks = 0;
   int errors = 0;

   add_arbiter #(.N(N), .IDW(IDW), .SETTLE(SETTLE)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
   endtask

   // One request through accept, latency, optional back-pressure and handshake.
   task automatic do_op(input string tag, input logic [3:0] mask, input int gid,
                        input logic [31:0] esum, input logic ecout, input int hold);
      @(negedge clk);
      req_valid = mask;
      #1;
      check({tag, "_grant"}, 64'(req_ready), 64'(4'b0001 << gid));
      @(negedge clk);
      req_valid = '0;
      for (int k = 1; k <= LAT; k++) begin
         if (k > 1) @(negedge clk);
         check({tag, "_lat"}, 64'(rsp_valid), 64'(k == LAT));
      end
      check({tag, "_sum"},  64'(rsp_sum),   64'(esum));
      check({tag, "_cout"}, 64'(rsp_cout),  64'(ecout));
      check({tag, "_id"},   64'(rsp_id),    64'(gid));
      check({tag, "_busy"}, 64'(busy),      64'(1));
      check({tag, "_rdy0"}, 64'(req_ready), 64'(0));
      $display("op %s: id=%0d sum=%08h cout=%0b", tag, rsp_id, rsp_sum, rsp_cout);
      for (int h = 0; h < hold; h++) begin
         req_valid = 4'hF;
         @(negedge clk);
         check({tag, "_hold_valid"}, 64'(rsp_valid), 64'(1));
         check({tag, "_hold_sum"},   64'(rsp_sum),   64'(esum));
         check({tag, "_hold_cout"},  64'(rsp_cout),  64'(ecout));
         check({tag, "_hold_id"},    64'(rsp_id),    64'(gid));
         check({tag, "_hold_busy"},  64'(busy),      64'(1));
         check({tag, "_hold_rdy"},   64'(req_ready), 64'(0));
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check({tag, "_drop"},      64'(rsp_valid), 64'(0));
      check({tag, "_idle_busy"}, 64'(busy),      64'(0));
   endtask

   initial begin
      int rr_id  [5];
      int rr_sum [5];
      int rr_cyc [5];
      int exp_id [5] = '{0, 1, 2, 3, 0};
      int exp_sum[5] = '{0, 2, 4, 6, 0};
      int n;

      rst       = 1'b1;
      req_valid = 4'hF;
      rsp_ready = 1'b0;
      req_a     = '0;
      req_b     = '0;
      for (int i = 0; i < N; i++) set_ops(i, 32'(i), 32'(i));

      // Reset held two cycles with every requester valid.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 64'(req_ready), 64'(0));
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_rsp_sum",   64'(rsp_sum),   64'(0));
      check("rst_rsp_id",    64'(rsp_id),    64'(0));
      check("rst_rsp_cout",  64'(rsp_cout),  64'(0));
      check("rst_busy",      64'(busy),      64'(0));
      rst = 1'b0;
      #1;
      check("rst_first_grant", 64'(req_ready), 64'(4'b0001));
      req_valid = '0;
      $display("reset: released, first grant offered to requester 0");

      // Round-robin with all requesters valid, operands i + i.
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      n = 0;
      for (int cyc = 0; cyc < 200 && n < 5; cyc++) begin
         @(negedge clk);
         if (rsp_valid) begin
            rr_id[n]  = int'(rsp_id);
            rr_sum[n] = int'(rsp_sum);
            rr_cyc[n] = cyc;
            $display("rr %0d: id=%0d sum=%08h cycle=%0d", n, rsp_id, rsp_sum, cyc);
            n++;
            if (n == 5) req_valid = '0;
         end
      end
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rr_count", 64'(n), 64'(5));
      for (int i = 0; i < n; i++) begin
         check("rr_id",  64'(rr_id[i]),  64'(exp_id[i]));
         check("rr_sum", 64'(rr_sum[i]), 64'(exp_sum[i]));
         if (i > 0) check("rr_gap", 64'(rr_cyc[i] - rr_cyc[i-1]), 64'(LAT + 1));
      end

      // Single request from requester 2 (ptr now 1).
      set_ops(2, 32'hA0A0FFFF, 32'hA0BFFFE0);
      do_op("single", 4'b0100, 2, 32'h4160FFDF, 1'b1, 0);

      // Wrap to zero with carry, then signed-overflow case with no carry.
      set_ops(0, 32'hFFFFFFFF, 32'h00000001);
      do_op("wrap", 4'b0001, 0, 32'h00000000, 1'b1, 0);
      set_ops(3, 32'h7FFFFFFF, 32'h00000001);
      do_op("nocarry", 4'b1000, 3, 32'h80000000, 1'b0, 0);

      // Back-pressure: RESP held 10 cycles with all requesters clamouring.
      set_ops(1, 32'h80000001, 32'h80000002);
      do_op("bp", 4'b0110, 1, 32'h00000003, 1'b1, 10);

      // Reset during ADD: requester 0 granted from ptr=2, then interrupted.
      @(negedge clk);
      req_valid = 4'b0001;
      #1;
      check("mid_grant", 64'(req_ready), 64'(4'b0001));
      @(negedge clk);
      req_valid = '0;
      check("mid_in_add", 64'(busy), 64'(1));
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", 64'(rsp_valid), 64'(0));
      check("mid_rst_busy",  64'(busy),      64'(0));
      rst = 1'b0;
      for (int c = 0; c < LAT + 4; c++) begin
         @(negedge clk);
         check("mid_no_rsp", 64'(rsp_valid), 64'(0));
      end
      $display("reset mid-op: in-flight operation discarded");
      // Requesters 0 and 2 valid: ptr must be back at 0.
      do_op("after_rst", 4'b0101, 0, 32'h00000000, 1'b1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
